// File: rtl/cle_p.sv
// Two-pass connected-component labeler: reads a 1-bpp bitmap from ROM, writes
// provisional labels to SRAM in pass 1, then rewrites them to final labels in pass 2.
module cle_p #(
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned IMG_H  = 32,
    parameter int unsigned ROM_DW = 8,
    parameter int unsigned LBL_W  = 8,
    parameter int unsigned CONN8  = 0,
    localparam int unsigned ROM_AW  = $clog2(IMG_W * IMG_H / ROM_DW),
    localparam int unsigned SRAM_AW = $clog2(IMG_W * IMG_H)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ROM_DW-1:0]  rom_q,
    output logic [ROM_AW-1:0]  rom_a,
    input  logic [LBL_W-1:0]   sram_q,
    output logic [SRAM_AW-1:0] sram_a,
    output logic [LBL_W-1:0]   sram_d,
    output logic               sram_wen,
    output logic               finish,
    output logic               overflow
);
    localparam int unsigned NLBL  = 1 << LBL_W;
    localparam int unsigned NWORD = IMG_W * IMG_H / ROM_DW;
    localparam int unsigned NPIX  = IMG_W * IMG_H;
    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned CNT_W = (ROM_DW > 1) ? $clog2(ROM_DW) : 1;
    localparam logic [LBL_W-1:0] MAX_LBL = LBL_W'(NLBL - 1);

    typedef enum logic [2:0] {
        IDLE, P1_FETCH, P1_WAIT, P1_LABEL, P2_RD, P2_WT, P2_WR, DONE
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [COL_W-1:0]   col, col_ur;
    logic [SRAM_AW-1:0] px;
    logic [ROM_DW-1:0]  sh;
    logic [LBL_W-1:0]   left_r, ul_r, next_lbl;
    logic [LBL_W-1:0]   lb [IMG_W];
    logic [LBL_W-1:0]   eq [NLBL];

    logic               init, do_label, cur_bit;
    logic               cnt_last, word_last, pix_last, col_last;
    logic [LBL_W-1:0]   nb [4];
    logic [LBL_W-1:0]   lo, hi, rep, lbl;
    logic               any_nb, merge, alloc;

    assign cnt_last  = (cnt == CNT_W'(ROM_DW - 1));
    assign word_last = (rom_a == ROM_AW'(NWORD - 1));
    assign pix_last  = (sram_a == SRAM_AW'(NPIX - 1));
    assign col_last  = (col == COL_W'(IMG_W - 1));
    assign col_ur    = col_last ? col : col + COL_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = P1_FETCH;
            P1_FETCH:   state_nxt = P1_WAIT;
            P1_WAIT:    state_nxt = P1_LABEL;
            P1_LABEL:   if (cnt_last) state_nxt = word_last ? P2_RD : P1_FETCH;
            P2_RD:      state_nxt = P2_WT;
            P2_WT:      state_nxt = P2_WR;
            P2_WR:      state_nxt = pix_last ? DONE : P2_RD;
            default:    state_nxt = IDLE;
        endcase
    end

    // Labels are computed one edge ahead so sram_a/sram_d are registered for each P1_LABEL cycle.
    always_comb begin
        init     = 1'b0;
        do_label = 1'b0;
        cur_bit  = 1'b0;
        case (state)
            IDLE, DONE: init = start;
            P1_WAIT: begin
                do_label = 1'b1;
                cur_bit  = rom_q[ROM_DW-1];
            end
            P1_LABEL: begin
                do_label = !cnt_last;
                cur_bit  = sh[ROM_DW-1];
            end
            default: ;
        endcase
    end

    // Neighbour representatives; at most two distinct values can appear.
    always_comb begin
        nb[0]  = (col == '0) ? '0 : left_r;
        nb[1]  = lb[col];
        nb[2]  = (CONN8 != 0 && col != '0) ? ul_r : '0;
        nb[3]  = (CONN8 != 0 && !col_last) ? lb[col_ur] : '0;
        lo     = '1;
        hi     = '0;
        rep    = '0;
        any_nb = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (nb[k] != '0) begin
                rep    = eq[nb[k]];
                any_nb = 1'b1;
                if (rep < lo) lo = rep;
                if (rep > hi) hi = rep;
            end
        end
        alloc = cur_bit && !any_nb;
        merge = cur_bit && any_nb && (hi != lo);
        if (!cur_bit)    lbl = '0;
        else if (any_nb) lbl = lo;
        else             lbl = next_lbl;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_a    <= '0;
            sram_a   <= '0;
            sram_d   <= '0;
            sram_wen <= 1'b1;
            finish   <= 1'b0;
            overflow <= 1'b0;
            next_lbl <= LBL_W'(1);
            px       <= '0;
            col      <= '0;
            cnt      <= '0;
            sh       <= '0;
            left_r   <= '0;
            ul_r     <= '0;
            for (int i = 0; i < IMG_W; i++) lb[i] <= '0;
            for (int i = 0; i < NLBL; i++)  eq[i] <= LBL_W'(i);
        end else if (init) begin
            rom_a    <= '0;
            sram_wen <= 1'b1;
            finish   <= 1'b0;
            overflow <= 1'b0;
            next_lbl <= LBL_W'(1);
            px       <= '0;
            col      <= '0;
            left_r   <= '0;
            ul_r     <= '0;
            for (int i = 0; i < IMG_W; i++) lb[i] <= '0;
            for (int i = 0; i < NLBL; i++)  eq[i] <= LBL_W'(i);
        end else begin
            case (state)
                P1_WAIT: begin
                    sh  <= rom_q << 1;
                    cnt <= '0;
                end
                P1_LABEL: begin
                    sh  <= sh << 1;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt_last) begin
                        sram_wen <= 1'b1;
                        if (word_last) sram_a <= '0;
                        else           rom_a  <= rom_a + ROM_AW'(1);
                    end
                end
                P2_WT: begin
                    sram_wen <= (sram_q == '0);
                    sram_d   <= eq[sram_q];
                end
                P2_WR: begin
                    sram_wen <= 1'b1;
                    if (pix_last) finish <= 1'b1;
                    else          sram_a <= sram_a + SRAM_AW'(1);
                end
                default: ;
            endcase
            if (do_label) begin
                sram_a   <= px;
                sram_d   <= lbl;
                sram_wen <= 1'b0;
                px       <= px + SRAM_AW'(1);
                col      <= col_last ? '0 : col + COL_W'(1);
                left_r   <= lbl;
                ul_r     <= lb[col];
                lb[col]  <= lbl;
                if (alloc) begin
                    if (next_lbl == MAX_LBL) overflow <= 1'b1;
                    else                     next_lbl <= next_lbl + LBL_W'(1);
                end
                // Keep eq flat: every alias of hi is redirected to lo at once.
                if (merge) begin
                    for (int i = 0; i < NLBL; i++)
                        if (eq[i] == hi) eq[i] <= lo;
                end
            end
        end
    end
endmodule

// File: tb/tb_cle_p.sv
// Bench for cle_p: three instances (4-conn, 8-conn, 2-bit labels) with
// synchronous ROM/SRAM models, directed vector table plus reset/start sequences.
module tb_cle_p;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [2:0] start_v = 3'b000;
    always #5 clk = ~clk;

    logic [6:0] rom_a0, rom_a1, rom_a2;
    logic [7:0] rom_q0, rom_q1, rom_q2;
    logic [9:0] sram_a0, sram_a1, sram_a2;
    logic [7:0] sram_d0, sram_d1, sram_q0, sram_q1;
    logic [1:0] sram_d2, sram_q2;
    logic       sram_wen0, sram_wen1, sram_wen2;
    logic       finish0, finish1, finish2, overflow0, overflow1, overflow2;
    logic [2:0] finish_v, overflow_v;
    assign finish_v   = {finish2, finish1, finish0};
    assign overflow_v = {overflow2, overflow1, overflow0};

    logic [7:0] rom [3][128];
    logic [7:0] sram0 [1024];
    logic [7:0] sram1 [1024];
    logic [1:0] sram2 [1024];

    cle_p #(.CONN8(0)) dut0 (.clk(clk), .reset(reset), .start(start_v[0]), .rom_q(rom_q0), .rom_a(rom_a0),
        .sram_q(sram_q0), .sram_a(sram_a0), .sram_d(sram_d0), .sram_wen(sram_wen0),
        .finish(finish0), .overflow(overflow0));
    cle_p #(.CONN8(1)) dut1 (.clk(clk), .reset(reset), .start(start_v[1]), .rom_q(rom_q1), .rom_a(rom_a1),
        .sram_q(sram_q1), .sram_a(sram_a1), .sram_d(sram_d1), .sram_wen(sram_wen1),
        .finish(finish1), .overflow(overflow1));
    cle_p #(.LBL_W(2)) dut2 (.clk(clk), .reset(reset), .start(start_v[2]), .rom_q(rom_q2), .rom_a(rom_a2),
        .sram_q(sram_q2), .sram_a(sram_a2), .sram_d(sram_d2), .sram_wen(sram_wen2),
        .finish(finish2), .overflow(overflow2));

    always @(posedge clk) rom_q0 <= rom[0][rom_a0];
    always @(posedge clk) rom_q1 <= rom[1][rom_a1];
    always @(posedge clk) rom_q2 <= rom[2][rom_a2];
    always @(posedge clk) begin
        if (!sram_wen0) sram0[sram_a0] <= sram_d0;
        sram_q0 <= sram0[sram_a0];
    end
    always @(posedge clk) begin
        if (!sram_wen1) sram1[sram_a1] <= sram_d1;
        sram_q1 <= sram1[sram_a1];
    end
    always @(posedge clk) begin
        if (!sram_wen2) sram2[sram_a2] <= sram_d2;
        sram_q2 <= sram2[sram_a2];
    end

    typedef struct packed {
        logic [1:0]        inst;
        logic [1:0]        na;
        logic [2:0][6:0]   ra;
        logic [2:0][7:0]   rd;
        logic [3:0]        ne;
        logic [11:0][9:0]  ea;
        logic [11:0][7:0]  ev;
        logic              ovf;
    } vec_t;

    localparam int NVEC = 8;
    localparam int T_FIN = 4352;
    vec_t vecs [NVEC];
    int tests = 0;
    int fails = 0;
    int fin_cyc [3];

    task automatic chk(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    function automatic int rd_sram(input int k, input int a);
        case (k)
            0:       return int'(sram0[a]);
            1:       return int'(sram1[a]);
            default: return int'(sram2[a]);
        endcase
    endfunction

    task automatic add_rom(input int i, input int a, input int d);
        vecs[i].ra[vecs[i].na] = 7'(a);
        vecs[i].rd[vecs[i].na] = 8'(d);
        vecs[i].na = vecs[i].na + 2'd1;
    endtask

    task automatic add_exp(input int i, input int a, input int v);
        vecs[i].ea[vecs[i].ne] = 10'(a);
        vecs[i].ev[vecs[i].ne] = 8'(v);
        vecs[i].ne = vecs[i].ne + 4'd1;
    endtask

    task automatic load(input int i);
        int k;
        k = int'(vecs[i].inst);
        for (int a = 0; a < 128; a++) rom[k][a] = 8'h00;
        for (int j = 0; j < int'(vecs[i].na); j++) rom[k][vecs[i].ra[j]] = vecs[i].rd[j];
    endtask

    task automatic kick(input logic [2:0] mask);
        @(negedge clk);
        start_v = mask;
        @(negedge clk);
        start_v = 3'b000;
    endtask

    task automatic run(input logic [2:0] mask);
        int n;
        bit done;
        kick(mask);
        for (int k = 0; k < 3; k++) begin
            fin_cyc[k] = -1;
            if (mask[k]) chk($sformatf("fin_clr%0d", k), int'(finish_v[k]), 0);
        end
        n = 0;
        done = 1'b0;
        while (!done && n < 6000) begin
            @(negedge clk);
            n++;
            done = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (mask[k]) begin
                    if (fin_cyc[k] < 0 && finish_v[k]) fin_cyc[k] = n;
                    if (fin_cyc[k] < 0) done = 1'b0;
                end
            end
        end
    endtask

    task automatic check_vec(input int i, input string tag);
        int want [1024];
        int bad;
        int k;
        k = int'(vecs[i].inst);
        bad = 0;
        for (int p = 0; p < 1024; p++) want[p] = 0;
        for (int j = 0; j < int'(vecs[i].ne); j++) want[vecs[i].ea[j]] = int'(vecs[i].ev[j]);
        for (int j = 0; j < int'(vecs[i].ne); j++)
            chk($sformatf("%s_px%0d", tag, vecs[i].ea[j]), rd_sram(k, int'(vecs[i].ea[j])),
                int'(vecs[i].ev[j]));
        for (int p = 0; p < 1024; p++)
            if (want[p] == 0 && rd_sram(k, p) != 0) bad++;
        chk({tag, "_bg_nonzero"}, bad, 0);
        chk({tag, "_ovf"}, int'(overflow_v[k]), int'(vecs[i].ovf));
        chk({tag, "_fin_cyc"}, fin_cyc[k], T_FIN);
    endtask

    initial begin
        int n;
        for (int i = 0; i < NVEC; i++) vecs[i] = '0;
        // v0: empty image
        vecs[0].inst = 2'd0;
        // v1: U shape, 4-connected
        vecs[1].inst = 2'd0; add_rom(1, 0, 8'hA0); add_rom(1, 4, 8'hE0);
        add_exp(1, 0, 1); add_exp(1, 2, 1); add_exp(1, 32, 1); add_exp(1, 33, 1); add_exp(1, 34, 1);
        // v2/v3: diagonal pair, 4- vs 8-connected
        vecs[2].inst = 2'd0; add_rom(2, 0, 8'h80); add_rom(2, 4, 8'h40);
        add_exp(2, 0, 1); add_exp(2, 33, 2);
        vecs[3].inst = 2'd1; add_rom(3, 0, 8'h80); add_rom(3, 4, 8'h40);
        add_exp(3, 0, 1); add_exp(3, 33, 1);
        // v4: label space exhausted with 2-bit labels
        vecs[4].inst = 2'd2; add_rom(4, 0, 8'hAA); vecs[4].ovf = 1'b1;
        add_exp(4, 0, 1); add_exp(4, 2, 2); add_exp(4, 4, 3); add_exp(4, 6, 3);
        // v5: last column of row 0 must not be the left neighbour of row 1 column 0
        vecs[5].inst = 2'd0; add_rom(5, 3, 8'h01); add_rom(5, 4, 8'h80);
        add_exp(5, 31, 1); add_exp(5, 32, 2);
        // v6: 8-conn up-right joins, row wrap does not
        vecs[6].inst = 2'd1; add_rom(6, 0, 8'h40); add_rom(6, 3, 8'h01); add_rom(6, 4, 8'h80);
        add_exp(6, 1, 1); add_exp(6, 31, 2); add_exp(6, 32, 1);
        // v7: chained merges where hi already has an alias
        vecs[7].inst = 2'd0; add_rom(7, 0, 8'hA8); add_rom(7, 4, 8'hB8); add_rom(7, 8, 8'hF8);
        add_exp(7, 0, 1); add_exp(7, 2, 1); add_exp(7, 4, 1); add_exp(7, 32, 1);
        add_exp(7, 34, 1); add_exp(7, 35, 1); add_exp(7, 36, 1); add_exp(7, 64, 1);
        add_exp(7, 65, 1); add_exp(7, 66, 1); add_exp(7, 67, 1); add_exp(7, 68, 1);
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 128; a++) rom[k][a] = 8'h00;

        #3 reset = 1'b0;
        @(negedge clk);
        chk("rst_rom_a", int'(rom_a0), 0);
        chk("rst_sram_a", int'(sram_a0), 0);
        chk("rst_sram_d", int'(sram_d0), 0);
        chk("rst_sram_wen", int'(sram_wen0), 1);
        chk("rst_finish", int'(finish0), 0);
        chk("rst_overflow", int'(overflow0), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            load(i);
            run(3'(1 << vecs[i].inst));
            check_vec(i, $sformatf("v%0d", i));
        end

        // Reset in the middle of pass 1, then rerun from scratch
        load(7);
        load(4);
        kick(3'b101);
        repeat (600) @(negedge clk);
        chk("mid_ovf_before_rst", int'(overflow2), 1);
        chk("mid_rom_a_nonzero", int'(rom_a0 != 7'd0), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_rom_a", int'(rom_a0), 0);
        chk("mid_rst_sram_a", int'(sram_a0), 0);
        chk("mid_rst_sram_d", int'(sram_d0), 0);
        chk("mid_rst_sram_wen", int'(sram_wen0), 1);
        chk("mid_rst_finish", int'(finish0), 0);
        chk("mid_rst_ovf2", int'(overflow2), 0);
        chk("mid_rst_sram_a2", int'(sram_a2), 0);
        repeat (3) @(negedge clk);
        chk("mid_rst_hold_rom_a", int'(rom_a0), 0);
        chk("mid_rst_hold_wen", int'(sram_wen0), 1);
        reset = 1'b1;
        run(3'b101);
        check_vec(7, "rerun7");
        check_vec(4, "rerun4");

        // start during pass 2 is ignored; a later start relabels a new image
        load(1);
        kick(3'b001);
        repeat (2000) @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        n = 2001;
        while (!finish0 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        fin_cyc[0] = finish0 ? n : -1;
        check_vec(1, "p2start");
        load(2);
        run(3'b001);
        check_vec(2, "restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cle_p.md
CLE_P -- requirements
Module: cle_p

Interface
REQ-001 Parameter IMG_W, 32, image width in pixels; SHALL be a multiple of ROM_DW.
REQ-002 Parameter IMG_H, 32, image height in pixels.
REQ-003 Parameter ROM_DW, 8, ROM word width; one bit per pixel.
REQ-004 Parameter LBL_W, 8, label width; MAX_LBL = 2^LBL_W-1.
REQ-005 Parameter CONN8, 0, connectivity: 0 = 4-connected (left, up); 1 = 8-connected (left, up-left, up, up-right).
REQ-006 Derived widths SHALL be ROM_AW = clog2(IMG_W*IMG_H/ROM_DW) and SRAM_AW = clog2(IMG_W*IMG_H).
REQ-007 clk  input  1  single clock; all state changes on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  run request, sampled only in IDLE or DONE.
REQ-010 rom_q  input  ROM_DW  ROM read data, valid the cycle after rom_a is presented.
REQ-011 rom_a  output  ROM_AW  ROM word address.
REQ-012 sram_q  input  LBL_W  SRAM read data, valid the cycle after sram_a is presented with sram_wen=1.
REQ-013 sram_a  output  SRAM_AW  SRAM pixel address.
REQ-014 sram_d  output  LBL_W  SRAM write data.
REQ-015 sram_wen  output  1  active-low write enable; write occurs on the clock edge while low.
REQ-016 finish  output  1  labeling complete; held until the next start.
REQ-017 overflow  output  1  sticky: label space exhausted during the current run.

Function
REQ-018 Pixel (r,c) SHALL be ROM word (r*IMG_W+c)/ROM_DW, bit ROM_DW-1-(c mod ROM_DW) (MSB = leftmost); foreground = 1.
REQ-019 Label of pixel (r,c) SHALL be stored at SRAM address r*IMG_W+c; background = 0.
REQ-020 States SHALL be IDLE, P1_FETCH, P1_WAIT, P1_LABEL, P2_RD, P2_WT, P2_WR, DONE.
REQ-021 On start in IDLE/DONE: init eq[i]=i for all i, next_lbl=1, line buffer=0, overflow=0, finish=0; go to P1_FETCH.
REQ-022 Pass 1, per ROM word: P1_FETCH drives rom_a (1 cycle); P1_WAIT (1 cycle); P1_LABEL for ROM_DW cycles, one pixel per cycle, left to right, writing every pixel (sram_wen=0).
REQ-023 Pass 1 cycles SHALL total IMG_W*IMG_H/ROM_DW*(ROM_DW+2); P1_LABEL wraps to P1_FETCH with next rom_a, or to P2_RD after the last pixel.
REQ-024 Neighbours SHALL come from a line buffer (previous row) and a left register; row 0, column 0 and column IMG_W-1 out-of-image neighbours read as 0.
REQ-025 Background pixel: write 0.
REQ-026 Foreground pixel with no nonzero neighbour: write next_lbl, then next_lbl increments.
REQ-027 If next_lbl = MAX_LBL: write MAX_LBL, no increment, set overflow.
REQ-028 Foreground pixel with nonzero neighbours: write lo = min of eq[n] over nonzero neighbours n.
REQ-029 If a second distinct representative hi exists, every eq[i]==hi SHALL become lo in the same cycle; at most two distinct representatives can occur.
REQ-030 Pass 2, per address 0..IMG_W*IMG_H-1: P2_RD drives sram_a with sram_wen=1; P2_WT; P2_WR drives sram_wen=0 and sram_d=eq[sram_q] if sram_q!=0, else sram_wen stays 1.
REQ-031 Pass 2 SHALL take 3 cycles per pixel; final label of each component = its smallest provisional label.
REQ-032 After the last P2_WR, go to DONE; finish SHALL be 1 from that edge; sram_wen=1 in IDLE/DONE.
REQ-033 start asserted in any other state SHALL be ignored.

Reset
REQ-034 reset low SHALL immediately force state=IDLE, rom_a=0, sram_a=0, sram_d=0, sram_wen=1, finish=0, overflow=0, next_lbl=1, line buffer=0, eq[i]=i; this holds mid-run, and a run is abandoned.

Verification (defaults unless stated; start pulsed at edge t0)
REQ-035 All-zero ROM -> SRAM all 0; finish=1 at t0+4352 (1280+3072 cycles); overflow=0.
REQ-036 ROM[0]=8'hA0, ROM[4]=8'hE0 (U shape), CONN8=0 -> SRAM[0,2,32,33,34]=1; all others 0.
REQ-037 ROM[0]=8'h80, ROM[4]=8'h40 (diagonal) -> CONN8=0: SRAM[0]=1, SRAM[33]=2; CONN8=1: both 1.
REQ-038 LBL_W=2, ROM[0]=8'hAA -> SRAM[0,2,4,6]=1,2,3,3; overflow=1.
REQ-039 reset low during pass 1, released, then start -> all outputs at reset values during reset; the rerun result matches the uninterrupted result.
REQ-040 start pulsed mid-pass 2 -> ignored; after DONE, a new start clears finish and relabels correctly.
